// File: rtl/cot_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cot_pwm_ctrl
// Description : Constant-on-time PWM controller for a synchronous buck
//               half-bridge. Sequences dead time, high-side on-time, dead
//               time and minimum low-side time from a valley trigger, with
//               sticky fault shutdown and an ON-entry cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cot_pwm_ctrl #(
   parameter int TON_W  = 21,
   parameter int TOFF_W = 16,
   parameter int DT_W   = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              trig,
   input  logic              fault,
   input  logic              fault_clr,
   input  logic [TON_W-1:0]  ton_time,
   input  logic [TOFF_W-1:0] toff_min,
   input  logic [DT_W-1:0]   dead_time,
   output logic              pwm_hs,
   output logic              pwm_ls,
   output logic              fault_latched,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_DT_LH   = 3'd2,
      S_ON      = 3'd3,
      S_DT_HL   = 3'd4,
      S_OFF_MIN = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DT_W-1:0]   r_dt_cnt;
   logic [TON_W-1:0]  r_ton_cnt;
   logic [TOFF_W-1:0] r_off_cnt;
   logic              r_hs;
   logic              r_ls;
   logic              r_flt;
   logic [CNT_W-1:0]  r_cycle_cnt;

   // Reload values: a programmed 0 behaves as 1, so the reload is max(x,1)-1.
   logic [DT_W-1:0]   w_dt_load;
   logic [TON_W-1:0]  w_ton_load;
   logic [TOFF_W-1:0] w_off_load;

   assign w_dt_load  = (dead_time == '0) ? '0 : dead_time - 1'b1;
   assign w_ton_load = (ton_time  == '0) ? '0 : ton_time  - 1'b1;
   assign w_off_load = (toff_min  == '0) ? '0 : toff_min  - 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; priority is fault, then enable loss, then trig/timers.
   always_comb begin
      w_state_nxt = r_state;
      if (fault) begin
         w_state_nxt = S_FAULT;
      end else if (r_state == S_FAULT) begin
         if (fault_clr) w_state_nxt = S_IDLE;
      end else if (!en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    w_state_nxt = S_WAIT;
            S_WAIT:    if (trig)             w_state_nxt = S_DT_LH;
            S_DT_LH:   if (r_dt_cnt  == '0)  w_state_nxt = S_ON;
            S_ON:      if (r_ton_cnt == '0)  w_state_nxt = S_DT_HL;
            S_DT_HL:   if (r_dt_cnt  == '0)  w_state_nxt = S_OFF_MIN;
            S_OFF_MIN: if (r_off_cnt == '0)  w_state_nxt = S_WAIT;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Phase timers: loaded on phase entry (latching the setting), then count down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dt_cnt  <= '0;
         r_ton_cnt <= '0;
         r_off_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         if (w_state_nxt == S_DT_LH || w_state_nxt == S_DT_HL) r_dt_cnt <= w_dt_load;
         if (w_state_nxt == S_ON)      r_ton_cnt <= w_ton_load;
         if (w_state_nxt == S_OFF_MIN) r_off_cnt <= w_off_load;
      end else begin
         if ((r_state == S_DT_LH || r_state == S_DT_HL) && r_dt_cnt != '0)
            r_dt_cnt <= r_dt_cnt - 1'b1;
         if (r_state == S_ON && r_ton_cnt != '0)
            r_ton_cnt <= r_ton_cnt - 1'b1;
         if (r_state == S_OFF_MIN && r_off_cnt != '0)
            r_off_cnt <= r_off_cnt - 1'b1;
      end
   end

   // Gate enables and fault flag decoded from the next state, so they move with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs  <= 1'b0;
         r_ls  <= 1'b0;
         r_flt <= 1'b0;
      end else begin
         r_hs  <= (w_state_nxt == S_ON);
         r_ls  <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_OFF_MIN);
         r_flt <= (w_state_nxt == S_FAULT);
      end
   end

   // Telemetry counter of ON entries; wraps freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cycle_cnt <= '0;
      else if (r_state == S_DT_LH && w_state_nxt == S_ON)
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
   end

   assign pwm_hs        = r_hs;
   assign pwm_ls        = r_ls;
   assign fault_latched = r_flt;
   assign state         = r_state;
   assign cycle_cnt     = r_cycle_cnt;

endmodule
`default_nettype wire
